// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS control unit and its datapath:
//   - opcode constants (instruction bits 31:26)
//   - FSM state encodings (S_RST .. S_ADDIWB)
//   - ALUOp / ALUSrcB / PCSource encodings, also used by the datapath muxes
//     and by the ALU control block
//   - ctrl_word_t, the control word produced by ctrl_output_decode
//   - op_supported(), which tells DECODE whether an opcode has a route
// Optional feature macro: CTRL_ADDI_EN (adds the addi instruction).
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // FSM states
    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;

    // ALUOp to the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_word_t;

    // True when DECODE has a destination state for this opcode.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_J);
`ifdef CTRL_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// ----------------------------------------------------------------------------
// ctrl_output_decode
// Combinational state -> control word decode for the multicycle control FSM.
// Every field defaults to 0, so any state not listed (including unreachable
// encodings) drives an all-zero control word.
// Optional feature macro: CTRL_ADDI_EN (decodes ADDIEX / ADDIWB).
// Ports:
//   state     in   current FSM state
//   mem_ready in   memory handshake; only gates PCWrite/IRWrite in FETCH
//   ctrl      out  decoded control word
// ----------------------------------------------------------------------------
module ctrl_output_decode
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic               mem_ready,
    output ctrl_word_t         ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALURES;
                // PC+4 and the IR are captured only once memory delivers.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_dst    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
// Main control unit for the multicycle MIPS datapath. A Moore FSM sequences
// fetch / decode / execute / memory / write-back one instruction at a time
// and drives every datapath select and enable through ctrl_output_decode.
// Optional feature macro: CTRL_ADDI_EN (addi via ADDIEX -> ADDIWB).
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   Op                  opcode from the instruction register
//   mem_ready           memory completed the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst
//                       datapath control outputs
//   illegal_op          pulse while in DECODE with an unsupported opcode
//   state               current state, for debug
// ----------------------------------------------------------------------------
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    Op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    ctrl_word_t         ctrl;

    // State register. Asserting rst_n forces RST immediately, which zeroes
    // every write enable in the same instant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RST:    state_next = S_FETCH;
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (Op == OP_RTYPE) begin
                    state_next = S_EXEC;
                end else if (Op == OP_BEQ) begin
                    state_next = S_BRANCH;
                end else if (Op == OP_J) begin
                    state_next = S_JUMP;
`ifdef CTRL_ADDI_EN
                end else if (Op == OP_ADDI) begin
                    state_next = S_ADDIEX;
`endif
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMADR: state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
`ifdef CTRL_ADDI_EN
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: state_next = S_FETCH;
`endif
            // Unreachable encodings recover through FETCH.
            default:  state_next = S_FETCH;
        endcase
    end

    // Output logic: control word from the registered state
    ctrl_output_decode #(
        .STATE_W (STATE_W)
    ) u_decode (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // The illegal-opcode flag is the one output that looks at Op directly;
    // it is valid for the single DECODE cycle that falls back to FETCH.
    always_comb begin
        illegal_op = (state_reg == S_DECODE) && !op_supported(Op);
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign state       = state_reg;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle MIPS datapath.
- Sequences one instruction at a time: fetch, decode, execute, memory access, write-back.
- Drives every datapath mux select and enable: RegDst, IorD, MemtoReg, ALUSrcA, ALUSrcB, PCSource, MemRead, MemWrite, plus PC/IR/register-file write enables and ALUOp to the ALU control.
- Stalls on a memory ready handshake. Flags unsupported opcodes.

Parameters:
- OP_W, 6, opcode width (instruction bits 31:26).
- STATE_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Op  input  OP_W  opcode from the instruction register.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU Zero (beq).
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  0 = ALUOut, 1 = MDR to register write data.
- PCSource  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- ALUSrcA  output  1  0 = PC, 1 = register A.
- ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  0 = rt (20:16), 1 = rd (15:11).
- illegal_op  output  1  one-cycle pulse on unsupported opcode.
- state  output  STATE_W  current state, for debug.

Behaviour:
- Moore FSM. All outputs are decoded from the registered state only; mem_ready affects only PCWrite and IRWrite.
- Unlisted outputs are 0 in every state.
- Reset (rst_n low, asynchronous):
  - state = RST (0); all outputs 0.
  - RST → FETCH on the first clock edge after rst_n goes high.
  - rst_n low mid-instruction aborts immediately to RST. No partial write-back: RegWrite, MemWrite and PCWrite drop the same instant.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - Held while mem_ready=0. On mem_ready=1 → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 0x23 (lw) and 0x2B (sw) → MEMADR.
  - 0x00 (R-type) → EXEC.
  - 0x04 (beq) → BRANCH.
  - 0x02 (j) → JUMP.
  - Any other opcode → FETCH, with illegal_op=1 for the DECODE→FETCH cycle (pulse asserted in DECODE, combinational on Op).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if Op=0x23, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Held until mem_ready=1, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. → FETCH.
- MEMWR: MemWrite=1, IorD=1. Held until mem_ready=1, then → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. → ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH.
- JUMP: PCWrite=1, PCSource=10. → FETCH.
- Cycle counts with mem_ready tied high:
  - lw = 5; sw = 4; R-type = 4; beq = 3; j = 3; illegal = 2.
  - Each mem_ready=0 cycle adds one.
- mem_ready high outside FETCH/MEMRD/MEMWR is ignored.
- Unreachable state encodings → FETCH next cycle, all outputs 0.

Optional Feature:
- Macro: CTRL_ADDI_EN.
- Defined:
  - DECODE routes Op=0x08 (addi) → ADDIEX.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. → ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. → FETCH.
  - addi takes 4 cycles.
- Undefined: states ADDIEX/ADDIWB are absent, and 0x08 is illegal (illegal_op pulse, → FETCH).

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - State localparams S_RST through S_ADDIWB.
  - ALUOp, ALUSrcB and PCSource encodings. The datapath muxes and ALU control use the same encodings.
- One sub-module: ctrl_output_decode, combinational state → control-word decode. The FSM top keeps the state register and next-state logic.

Test Plan:
- Reset: rst_n=0 mid-MEMWR → MemWrite=0 immediately, state=0. Release → FETCH after 1 clock.
- lw, Op=0x23, mem_ready=1 → sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5. Then back to FETCH.
- sw with mem_ready low 3 cycles in MEMWR → MemWrite held 4 cycles, IorD=1 throughout, no RegWrite; 7 cycles total.
- R-type then beq then j → ALUOp 10/01/00 in their exec states. PCWriteCond=1 only in BRANCH. PCSource=10 and PCWrite=1 in JUMP.
- FETCH stall, mem_ready=0 for 5 cycles → MemRead=1, IRWrite=0, PCWrite=0 throughout. Both pulse together when mem_ready=1.
- Op=0x08:
  - Without CTRL_ADDI_EN → illegal_op pulses 1 cycle, FETCH next.
  - With CTRL_ADDI_EN → ADDIEX/ADDIWB, RegWrite with RegDst=0, 4 cycles.
